// File: rtl/uart_rx_os16.sv
// 16x-oversampling 8N1 UART receiver driven by a toggling rx_tick level.
// Bytes appear on data_out with a one-cycle data_valid; bad stop bits pulse framing_err.
`timescale 1ns/1ps
module uart_rx_os16 #(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    output logic                 framing_err,
    output logic                 busy
);

    localparam int unsigned OS_W = $clog2(OVERSAMPLE);
    localparam int unsigned BC_W = $clog2(DATA_BITS + 1);
    localparam logic [OS_W-1:0] OS_HALF = OS_W'(OVERSAMPLE / 2 - 1);
    localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);
    localparam logic [BC_W-1:0] BC_LAST = BC_W'(DATA_BITS - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t               state, state_nx;
    logic                 rx_meta, rx_s;
    logic                 tick_d, tick_ok, strobe_raw, strobe;
    logic [OS_W-1:0]      os_cnt, os_nx;
    logic [BC_W-1:0]      bit_cnt, bc_nx;
    logic [DATA_BITS-1:0] shift, shift_nx;
    logic [DATA_BITS-1:0] dout_nx;
    logic                 armed, armed_nx;
    logic                 valid_nx, ferr_nx;

    // tick_d resets to 0, so the first transition seen may be spurious; tick_ok masks it.
    assign strobe_raw = rx_tick ^ tick_d;
    assign strobe     = strobe_raw & tick_ok;
    assign busy       = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta     <= 1'b1;
            rx_s        <= 1'b1;
            tick_d      <= 1'b0;
            tick_ok     <= 1'b0;
            state       <= IDLE;
            os_cnt      <= '0;
            bit_cnt     <= '0;
            shift       <= '0;
            armed       <= 1'b0;
            data_out    <= '0;
            data_valid  <= 1'b0;
            framing_err <= 1'b0;
        end else begin
            rx_meta     <= rx;
            rx_s        <= rx_meta;
            tick_d      <= rx_tick;
            tick_ok     <= tick_ok | strobe_raw;
            state       <= state_nx;
            os_cnt      <= os_nx;
            bit_cnt     <= bc_nx;
            shift       <= shift_nx;
            armed       <= armed_nx;
            data_out    <= dout_nx;
            data_valid  <= valid_nx;
            framing_err <= ferr_nx;
        end
    end

    always_comb begin
        state_nx = state;
        os_nx    = os_cnt;
        bc_nx    = bit_cnt;
        shift_nx = shift;
        armed_nx = armed;
        dout_nx  = data_out;
        valid_nx = 1'b0;
        ferr_nx  = 1'b0;
        if (strobe) begin
            case (state)
                IDLE: begin
                    if (rx_s) begin
                        armed_nx = 1'b1;
                    end else if (armed) begin
                        state_nx = START;
                        os_nx    = '0;
                        armed_nx = 1'b0;
                    end
                end
                START: begin
                    if (os_cnt == OS_HALF) begin
                        os_nx = '0;
                        if (!rx_s) begin
                            state_nx = DATA;
                            bc_nx    = '0;
                        end else begin
                            state_nx = IDLE;
                        end
                    end else begin
                        os_nx = os_cnt + OS_W'(1);
                    end
                end
                DATA: begin
                    if (os_cnt == OS_LAST) begin
                        os_nx    = '0;
                        shift_nx = {rx_s, shift[DATA_BITS-1:1]};
                        bc_nx    = bit_cnt + BC_W'(1);
                        if (bit_cnt == BC_LAST) state_nx = STOP;
                    end else begin
                        os_nx = os_cnt + OS_W'(1);
                    end
                end
                STOP: begin
                    if (os_cnt == OS_LAST) begin
                        os_nx    = '0;
                        state_nx = IDLE;
                        if (rx_s) begin
                            dout_nx  = shift;
                            valid_nx = 1'b1;
                        end else begin
                            ferr_nx = 1'b1;
                        end
                    end else begin
                        os_nx = os_cnt + OS_W'(1);
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

endmodule

// File: doc/uart_rx_os16.md
# uart_rx_os16

16x-oversampling UART receiver: the receive-side consumer of the baud-rate generator's `rx_tick` output. It turns the asynchronous serial line `rx` into parallel bytes. The frame format is 8N1: one start bit, DATA_BITS data bits LSB first, no parity, one stop bit. Each received byte appears on `data_out` with a one-cycle `data_valid` pulse. Stop-bit errors are reported on `framing_err`.

## Interface
- DATA_BITS, 8, data bits per frame (5..9)
- OVERSAMPLE, 16, sample strobes per bit period (even, ≥4)
- clk  input  1  system clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- rx_tick  input  1  oversample tick from the baud generator; a level that toggles once per 1/(16·baud); every transition (either edge) is one sample strobe
- rx  input  1  asynchronous serial line, idle high
- data_out  output  DATA_BITS  last correctly framed byte; holds until the next good frame
- data_valid  output  1  one-cycle pulse: data_out updated this cycle
- framing_err  output  1  one-cycle pulse: stop bit sampled low
- busy  output  1  high whenever state ≠ IDLE

## Operation
- Line input: a 2-flop synchronizer on `rx` produces `rx_s`. All decisions use `rx_s` only.
- Strobe: register `tick_d` ← `rx_tick`; `strobe` = `rx_tick ^ tick_d`. The first strobe after reset is discarded, because `tick_d` resets to 0 and may not match `rx_tick`.
- Counters: `os_cnt` is log2(OVERSAMPLE) bits and advances only on `strobe`. `bit_cnt` is log2(DATA_BITS+1) bits. The shift register is DATA_BITS wide and shifts right, with the new bit entering the MSB.
- `armed` flag: set when `rx_s`=1 is seen in IDLE; cleared on entry to START. A line held low (break) therefore never starts a second frame until it returns high.
- FSM transitions:
  - IDLE: on `strobe` with `armed` and `rx_s`=0 → START, `os_cnt`←0.
  - START: on `strobe`, `os_cnt`++. When `os_cnt` reaches OVERSAMPLE/2−1 (mid start bit):
    - `rx_s`=0 → DATA, `os_cnt`←0, `bit_cnt`←0.
    - otherwise → IDLE (glitch reject, no outputs pulse).
  - DATA: on `strobe`, `os_cnt`++. When `os_cnt` = OVERSAMPLE−1 (mid data bit):
    - shift `rx_s` in; `os_cnt`←0; `bit_cnt`++.
    - after the DATA_BITS-th sample → STOP.
  - STOP: on `strobe`, `os_cnt`++. When `os_cnt` = OVERSAMPLE−1 (mid stop bit):
    - `rx_s`=1 → `data_out`←shift reg, pulse `data_valid`.
    - `rx_s`=0 → pulse `framing_err`; `data_out` is unchanged.
    - either case → IDLE.
- `rx` activity between strobes is ignored. Only values sampled at strobes matter.

## Timing
- Reset values: `data_out`=0, `data_valid`=0, `framing_err`=0, `busy`=0, state=IDLE, `armed`=0, counters=0, `tick_d`=0, synchronizer flops=1.
- Reset asserted mid-frame: on the next edge the block is in IDLE with all outputs at reset values. The partial byte is lost, and a fresh high line is required before the next start.
- `rx` to `rx_s` latency is 2 clk. `rx_tick` edge to `strobe` latency is 0 clk (same cycle as the sampled transition).
- `data_valid` and `framing_err` are registered. Each rises one clk after the clock edge on which the stop-bit strobe is processed, and lasts exactly 1 clk. The two never assert together.
- Frame length from the start-bit falling edge to the stop sample is about (0.5 + DATA_BITS + 1)·OVERSAMPLE strobes: 152 strobes at the defaults.
- Back-to-back frames: the receiver returns to IDLE mid stop bit, so a start edge immediately after the stop bit is caught. `armed` is already set because the stop bit was high.
- No strobe gaps are required. Strobes on consecutive clocks are legal.

## Test plan
- Reset/idle:
  - Stimulus: hold `rst`=1 for 3 clk with `rx`=1 and `rx_tick` toggling every 4 clk.
  - Required: all outputs 0; with `rx` held high for 500 clk afterwards, no `data_valid` and `busy`=0.
- Single byte:
  - Stimulus: `rx_tick` toggles every 4 clk (one bit = 64 clk); send 0xA5 in 8N1.
  - Required: exactly one `data_valid` pulse with `data_out`=0xA5; `framing_err` never asserted.
- Back-to-back:
  - Stimulus: send 0x00, 0xFF, 0x3C with no idle gap between frames.
  - Required: three `data_valid` pulses in order carrying 0x00, 0xFF, 0x3C.
- Glitch reject:
  - Stimulus: drive `rx` low for 3 strobes (shorter than OVERSAMPLE/2), then high.
  - Required: `busy` returns to 0; no `data_valid` or `framing_err`.
- Framing error and break:
  - Stimulus: send 0x55 with the stop bit low, then keep `rx` low for 40 bit times, then send 0x81.
  - Required: one `framing_err` pulse with `data_out` unchanged; no activity during the break; then `data_valid` with `data_out`=0x81.
- Reset mid-frame:
  - Stimulus: assert `rst` for 1 clk during data bit 4 of 0x96, then send 0x42 after the line has been high for 1 bit time.
  - Required: no output pulse for the first frame; `data_valid` with `data_out`=0x42.
